// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer slice.
// Holds the structural constants (depth, lane counts, register file size),
// derived widths, the entry tag type and the packed ROB entry record.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH    = 16;
  localparam int RETIRE_WIDTH = 2;
  localparam int CPL_WIDTH    = 2;
  localparam int NUM_AREGS    = 32;
  localparam int DATA_W       = 32;

  localparam int AREG_W = $clog2(NUM_AREGS);
  localparam int IDX_W  = $clog2(ROB_DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int RCNT_W = $clog2(RETIRE_WIDTH + 1);

  typedef logic [IDX_W-1:0]  rob_idx_t;
  typedef logic [AREG_W-1:0] areg_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dst;
    areg_t             dst_reg;
    logic [DATA_W-1:0] result;
  } rob_entry_t;

endpackage

// File: rtl/arch_reg_file_reorder_buffer_if.sv
// One register-file write lane between the reorder buffer and the
// architectural register file.
//   valid   : write strobe
//   dst_reg : register written
//   result  : value written
interface arch_reg_file_reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic              valid;
  areg_t             dst_reg;
  logic [DATA_W-1:0] result;

  modport rob (output valid, output dst_reg, output result);
  modport rf  (input  valid, input  dst_reg, input  result);
endinterface

// File: rtl/reorder_buffer_retire_select.sv
// Combinational retire selection over the RETIRE_WIDTH oldest entries.
//   ents      : entries in head order (lane 0 = head)
//   count     : occupied entries, caps how many lanes may retire
//   ret_mask  : lane retires this cycle
//   wr_en     : lane writes the register file
//   wr_dst    : per-lane destination register
//   wr_result : per-lane result value
//   ret_cnt   : number of lanes retiring
module rob_retire_select
  import reorder_buffer_pkg::*;
(
  input  rob_entry_t [RETIRE_WIDTH-1:0]             ents,
  input  logic       [CNT_W-1:0]                    count,
  output logic       [RETIRE_WIDTH-1:0]             ret_mask,
  output logic       [RETIRE_WIDTH-1:0]             wr_en,
  output areg_t      [RETIRE_WIDTH-1:0]             wr_dst,
  output logic       [RETIRE_WIDTH-1:0][DATA_W-1:0] wr_result,
  output logic       [RCNT_W-1:0]                   ret_cnt
);

  // Only a contiguous run of completed entries starting at head may retire.
  always_comb begin
    logic prefix;
    prefix   = 1'b1;
    ret_mask = '0;
    ret_cnt  = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      prefix      = prefix && ents[j].valid && ents[j].done && (CNT_W'(j) < count);
      ret_mask[j] = prefix;
      if (prefix) ret_cnt = ret_cnt + RCNT_W'(1);
    end
  end

  // The register file has no lane ordering, so an older lane yields to any
  // younger retiring lane writing the same register.
  always_comb begin
    wr_en = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      wr_en[j] = ret_mask[j] && ents[j].has_dst;
      for (int k = j + 1; k < RETIRE_WIDTH; k++) begin
        if (ret_mask[k] && ents[k].has_dst && (ents[k].dst_reg == ents[j].dst_reg))
          wr_en[j] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      wr_dst[j]    = ents[j].dst_reg;
      wr_result[j] = ents[j].result;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit stage ahead of the architectural register file.
// Allocates a tag per dispatched instruction, records out-of-order
// completions and retires up to RETIRE_WIDTH completed entries per cycle
// from the head, in program order.
//   clk, rst         : clock, synchronous active-low reset
//   disp_*           : dispatch handshake, destination, allocated tag
//   cpl_*            : CPL_WIDTH completion ports (tag + result)
//   flush            : discard all entries
//   rob_if           : RETIRE_WIDTH register-file write lanes
//   count, empty     : occupancy
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic                               disp_has_dst,
  input  areg_t                              disp_dst_reg,
  output rob_idx_t                           disp_idx,
  input  logic                               cpl_valid  [CPL_WIDTH],
  input  rob_idx_t                           cpl_idx    [CPL_WIDTH],
  input  logic [DATA_W-1:0]                  cpl_result [CPL_WIDTH],
  input  logic                               flush,
  arch_reg_file_reorder_buffer_if.rob        rob_if     [RETIRE_WIDTH],
  output logic [CNT_W-1:0]                   count,
  output logic                               empty
);

  logic [ROB_DEPTH-1:0] ent_valid;
  logic [ROB_DEPTH-1:0] ent_done;
  logic                 ent_has_dst [ROB_DEPTH];
  areg_t                ent_dst     [ROB_DEPTH];
  logic [DATA_W-1:0]    ent_result  [ROB_DEPTH];

  rob_idx_t          head;
  rob_idx_t          tail;
  logic [CNT_W-1:0]  cnt_q;
  logic              fire;

  rob_idx_t                          hd_slot [RETIRE_WIDTH];
  rob_entry_t [RETIRE_WIDTH-1:0]     hd_ents;
  logic [RETIRE_WIDTH-1:0]           ret_mask;
  logic [RETIRE_WIDTH-1:0]           wr_en;
  areg_t [RETIRE_WIDTH-1:0]          wr_dst;
  logic [RETIRE_WIDTH-1:0][DATA_W-1:0] wr_result;
  logic [RCNT_W-1:0]                 ret_cnt;

  // Readiness deliberately ignores same-cycle retirement to keep it off the
  // retire-select path.
  assign disp_ready = rst && (cnt_q < CNT_W'(ROB_DEPTH));
  assign fire       = disp_valid && disp_ready;
  assign disp_idx   = tail;
  assign count      = cnt_q;
  assign empty      = (cnt_q == '0);

  always_comb begin
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      hd_slot[j]         = head + IDX_W'(j);
      hd_ents[j].valid   = ent_valid[hd_slot[j]];
      hd_ents[j].done    = ent_done[hd_slot[j]];
      hd_ents[j].has_dst = ent_has_dst[hd_slot[j]];
      hd_ents[j].dst_reg = ent_dst[hd_slot[j]];
      hd_ents[j].result  = ent_result[hd_slot[j]];
    end
  end

  rob_retire_select u_sel (
    .ents      (hd_ents),
    .count     (cnt_q),
    .ret_mask  (ret_mask),
    .wr_en     (wr_en),
    .wr_dst    (wr_dst),
    .wr_result (wr_result),
    .ret_cnt   (ret_cnt)
  );

  // Lanes are driven from pre-update state, so a flush cycle still commits;
  // rst gates the strobe so a mid-stream reset writes nothing.
  for (genvar j = 0; j < RETIRE_WIDTH; j++) begin : g_lane
    assign rob_if[j].valid   = rst && wr_en[j];
    assign rob_if[j].dst_reg = wr_dst[j];
    assign rob_if[j].result  = wr_result[j];
  end

  // Control state: flush shares the reset path and overrides every update.
  // Completion targets must already be valid, so a tag being allocated this
  // cycle is never marked done; retire clears follow completions.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head      <= '0;
      tail      <= '0;
      cnt_q     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      for (int k = 0; k < CPL_WIDTH; k++) begin
        if (cpl_valid[k] && ent_valid[cpl_idx[k]]) ent_done[cpl_idx[k]] <= 1'b1;
      end
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
        if (ret_mask[j]) begin
          ent_valid[hd_slot[j]] <= 1'b0;
          ent_done[hd_slot[j]]  <= 1'b0;
        end
      end
      if (fire) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
      end
      head  <= head + IDX_W'(ret_cnt);
      tail  <= tail + IDX_W'(fire);
      cnt_q <= cnt_q + CNT_W'(fire) - CNT_W'(ret_cnt);
    end
  end

  // Payload: no reset, qualified by ent_valid. x0 never gets has_dst.
  // Ascending port order lets the higher port win on a shared tag.
  always_ff @(posedge clk) begin
    if (fire) begin
      ent_has_dst[tail] <= disp_has_dst && (disp_dst_reg != '0);
      ent_dst[tail]     <= disp_dst_reg;
    end
    for (int k = 0; k < CPL_WIDTH; k++) begin
      if (cpl_valid[k] && ent_valid[cpl_idx[k]]) ent_result[cpl_idx[k]] <= cpl_result[k];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: table of single-instruction vectors plus
// hand-written multi-cycle sequences; a negedge monitor compares every
// register-file write against a queue of expected writes.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              disp_valid;
  logic              disp_ready;
  logic              disp_has_dst;
  areg_t             disp_dst_reg;
  rob_idx_t          disp_idx;
  logic              cpl_valid  [CPL_WIDTH];
  rob_idx_t          cpl_idx    [CPL_WIDTH];
  logic [DATA_W-1:0] cpl_result [CPL_WIDTH];
  logic              flush;
  logic [CNT_W-1:0]  count;
  logic              empty;

  arch_reg_file_reorder_buffer_if rob_if [RETIRE_WIDTH] ();

  logic              lv [RETIRE_WIDTH];
  areg_t             ld [RETIRE_WIDTH];
  logic [DATA_W-1:0] lr [RETIRE_WIDTH];

  for (genvar j = 0; j < RETIRE_WIDTH; j++) begin : g_mon
    assign lv[j] = rob_if[j].valid;
    assign ld[j] = rob_if[j].dst_reg;
    assign lr[j] = rob_if[j].result;
  end

  reorder_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_has_dst (disp_has_dst),
    .disp_dst_reg (disp_dst_reg),
    .disp_idx     (disp_idx),
    .cpl_valid    (cpl_valid),
    .cpl_idx      (cpl_idx),
    .cpl_result   (cpl_result),
    .flush        (flush),
    .rob_if       (rob_if),
    .count        (count),
    .empty        (empty)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    areg_t             dst;
    logic [DATA_W-1:0] res;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  typedef struct {
    logic              has_dst;
    areg_t             dst;
    logic [DATA_W-1:0] res;
    logic              exp_wr;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle's write lanes are consumed once, lane 0 first.
  always @(negedge clk) begin
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      if (lv[j] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write lane %0d: got dst %0d res %h expected no write", j, ld[j], lr[j]);
        end else begin
          mon_e = exp_q.pop_front();
          if (ld[j] !== mon_e.dst || lr[j] !== mon_e.res) begin
            errors++;
            $display("FAIL scoreboard lane %0d: got dst %0d res %h expected dst %0d res %h",
                     j, ld[j], lr[j], mon_e.dst, mon_e.res);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid   = 1'b0;
    disp_has_dst = 1'b0;
    disp_dst_reg = '0;
    flush        = 1'b0;
    for (int k = 0; k < CPL_WIDTH; k++) begin
      cpl_valid[k]  = 1'b0;
      cpl_idx[k]    = '0;
      cpl_result[k] = '0;
    end
  endtask

  task automatic step();
    cyc();
    idle();
  endtask

  task automatic set_cpl(input int port, input rob_idx_t tag, input logic [DATA_W-1:0] res);
    cpl_valid[port]  = 1'b1;
    cpl_idx[port]    = tag;
    cpl_result[port] = res;
  endtask

  task automatic dispatch(input logic hd, input areg_t d, output rob_idx_t tag);
    chk("disp_ready", disp_ready, 1);
    disp_valid   = 1'b1;
    disp_has_dst = hd;
    disp_dst_reg = d;
    tag          = disp_idx;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    cyc();
    cyc();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", disp_ready, 0);
    chk("rst_idx", disp_idx, 0);
    chk("rst_lane0", lv[0], 0);
    rst = 1'b1;
    #1;
  endtask

  rob_idx_t tg;

  initial begin
    rst = 1'b0;
    idle();

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b0, 5'd9,  32'h11111111, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  32'h22222222, 1'b0};
    vecs[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1};
    vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1};

    do_reset();
    chk("ready_after_rst", disp_ready, 1);

    // Single instruction: dispatch, complete, retire on lane 0.
    for (int i = 0; i < 5; i++) begin
      chk("vec_tag", disp_idx, i);
      dispatch(vecs[i].has_dst, vecs[i].dst, tg);
      chk("vec_cnt_disp", count, 1);
      chk("vec_not_done", lv[0], 0);
      if (vecs[i].exp_wr) exp_q.push_back('{vecs[i].dst, vecs[i].res});
      set_cpl(0, tg, vecs[i].res);
      step();
      chk("vec_wr", lv[0], vecs[i].exp_wr);
      if (vecs[i].exp_wr) begin
        chk("vec_dst", ld[0], vecs[i].dst);
        chk("vec_res", lr[0], vecs[i].res);
      end
      chk("vec_cnt_pre", count, 1);
      cyc();
      chk("vec_cnt_post", count, 0);
      chk("vec_empty", empty, 1);
    end

    // Out-of-order completion, contiguous prefix retire.
    do_reset();
    dispatch(1'b1, 5'd10, tg);
    dispatch(1'b1, 5'd11, tg);
    dispatch(1'b1, 5'd12, tg);
    set_cpl(0, 4'd2, 32'h0000_2222);
    step();
    chk("ooo_no_retire", lv[0], 0);
    exp_q.push_back('{5'd10, 32'h0000_AAAA});
    set_cpl(0, 4'd0, 32'h0000_AAAA);
    step();
    chk("ooo_l0", lv[0], 1);
    chk("ooo_l1_blocked", lv[1], 0);
    cyc();
    chk("ooo_cnt2", count, 2);
    exp_q.push_back('{5'd11, 32'h0000_1111});
    exp_q.push_back('{5'd12, 32'h0000_2222});
    set_cpl(1, 4'd1, 32'h0000_1111);
    step();
    chk("ooo_pair_l0", lv[0], 1);
    chk("ooo_pair_l1", lv[1], 1);
    chk("ooo_pair_dst1", ld[1], 12);
    cyc();
    chk("ooo_cnt0", count, 0);

    // Same destination retiring together: youngest lane wins.
    do_reset();
    dispatch(1'b1, 5'd7, tg);
    dispatch(1'b1, 5'd7, tg);
    exp_q.push_back('{5'd7, 32'h2});
    set_cpl(0, 4'd0, 32'h1);
    set_cpl(1, 4'd1, 32'h2);
    step();
    chk("samedst_l0", lv[0], 0);
    chk("samedst_l1", lv[1], 1);
    chk("samedst_res", lr[1], 32'h2);
    // Both ports hit one tag: higher port wins.
    dispatch(1'b1, 5'd8, tg);
    chk("sametag_tag", tg, 2);
    exp_q.push_back('{5'd8, 32'h44});
    set_cpl(0, 4'd2, 32'h33);
    set_cpl(1, 4'd2, 32'h44);
    step();
    chk("sametag_res", lr[0], 32'h44);
    cyc();
    chk("sametag_cnt", count, 0);

    // Fill, stall, retire, wrap.
    do_reset();
    for (int i = 0; i < ROB_DEPTH; i++) begin
      chk("fill_idx", disp_idx, i);
      dispatch(1'b1, areg_t'(i + 1), tg);
    end
    chk("full_ready", disp_ready, 0);
    chk("full_count", count, 16);
    chk("full_wrap_idx", disp_idx, 0);
    exp_q.push_back('{5'd1, 32'h100});
    exp_q.push_back('{5'd2, 32'h101});
    set_cpl(0, 4'd0, 32'h100);
    set_cpl(1, 4'd1, 32'h101);
    step();
    chk("full_retiring_l0", lv[0], 1);
    chk("full_retiring_l1", lv[1], 1);
    chk("full_retiring_ready", disp_ready, 0);
    cyc();
    chk("after_ret_count", count, 14);
    chk("after_ret_ready", disp_ready, 1);
    dispatch(1'b1, 5'd17, tg);
    chk("wrap_tag0", tg, 0);
    dispatch(1'b1, 5'd18, tg);
    chk("wrap_tag1", tg, 1);
    chk("refull_count", count, 16);
    for (int i = 2; i < 18; i += 2) begin
      exp_q.push_back('{areg_t'(i + 1), 32'h100 + i});
      exp_q.push_back('{areg_t'(i + 2), 32'h100 + i + 1});
      set_cpl(0, rob_idx_t'(i), 32'h100 + i);
      set_cpl(1, rob_idx_t'(i + 1), 32'h100 + i + 1);
      step();
    end
    for (int n = 0; n < 30 && !empty; n++) cyc();
    chk("drain_empty", empty, 1);

    // Flush with retiring lanes, same-cycle dispatch and completion.
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(1'b1, areg_t'(20 + i), tg);
    set_cpl(0, 4'd1, 32'h501);
    set_cpl(1, 4'd2, 32'h502);
    step();
    exp_q.push_back('{5'd20, 32'h500});
    exp_q.push_back('{5'd21, 32'h501});
    set_cpl(0, 4'd0, 32'h500);
    step();
    chk("preflush_l0", lv[0], 1);
    chk("preflush_l1", lv[1], 1);
    flush        = 1'b1;
    disp_valid   = 1'b1;
    disp_has_dst = 1'b1;
    disp_dst_reg = 5'd26;
    set_cpl(0, 4'd3, 32'h503);
    step();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_idx", disp_idx, 0);
    chk("flush_ready", disp_ready, 1);
    for (int n = 0; n < 4; n++) cyc();
    dispatch(1'b1, 5'd25, tg);
    chk("postflush_tag", tg, 0);
    chk("postflush_wait", lv[0], 0);
    exp_q.push_back('{5'd25, 32'h600});
    set_cpl(0, 4'd0, 32'h600);
    step();
    chk("postflush_l0", lv[0], 1);
    cyc();
    chk("postflush_cnt", count, 0);

    // Reset mid-stream: nothing commits in the reset cycle.
    do_reset();
    for (int i = 0; i < 3; i++) dispatch(1'b1, areg_t'(3 + i), tg);
    set_cpl(0, 4'd1, 32'h701);
    step();
    set_cpl(0, 4'd0, 32'h700);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_l0", lv[0], 0);
    chk("midrst_l1", lv[1], 0);
    chk("midrst_ready", disp_ready, 0);
    cyc();
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_idx", disp_idx, 0);
    rst = 1'b1;
    for (int n = 0; n < 4; n++) cyc();
    dispatch(1'b1, 5'd9, tg);
    chk("midrst_newtag", tg, 0);
    exp_q.push_back('{5'd9, 32'h800});
    set_cpl(1, 4'd0, 32'h800);
    step();
    cyc();
    chk("midrst_final_cnt", count, 0);

    cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
